// File: rtl/mult16_share_sched.sv
// Round-robin scheduler sharing one pipelined 16x16 signed multiplier among NREQ requesters,
// with ID tagging and an in-order, credit-limited result FIFO. Optional macro: MULT_SCHED_PRIO_EN.
module mult16_share_sched #(
  parameter int NREQ   = 4,
  parameter int LAT    = 3,
  parameter int FDEPTH = 4
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic [15:0]          mul_a,
  output logic [15:0]          mul_b,
  output logic                 mul_vld_o,
  input  logic [31:0]          mul_p_i,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_p,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic                 busy
);
  localparam int IDW = $clog2(NREQ);
  localparam int PW  = $clog2(FDEPTH);
  localparam int CW  = PW + 1;
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]     CNT_MAX  = CW'(FDEPTH);
  localparam logic [PW-1:0]     PTR_ONE  = PW'(1);
  localparam logic [IDW:0]      NREQ_EXT = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0]    ID_LAST  = IDW'(NREQ - 1);
  localparam logic [NREQ-1:0]   OH_ONE   = {{(NREQ-1){1'b0}}, 1'b1};

  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]     inflight_q, inflight_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [15:0]       mul_a_q, mul_a_d;
  logic [15:0]       mul_b_q, mul_b_d;
  logic              mul_vld_q, mul_vld_d;
  logic [IDW-1:0]    issue_id_q, issue_id_d;
  logic [LAT-1:0]    tag_vld_q;
  logic [IDW-1:0]    tag_id_q  [LAT];
  logic [31:0]       fifo_p_q  [FDEPTH];
  logic [IDW-1:0]    fifo_id_q [FDEPTH];

  logic [NREQ-1:0]   search_s;
  logic [2*NREQ-1:0] dbl_s;
  logic [NREQ-1:0]   rot_s;
  logic [IDW-1:0]    off_s;
  logic [IDW:0]      sum_s;
  logic [IDW-1:0]    gnt_id_s;
  logic              hit_s;
  logic              rr_adv_s;
  logic              credit_ok_s;
  logic [CW-1:0]     outstanding_s;
  logic              xfer_s;
  logic              push_s;
  logic              pop_s;
  logic              fifo_nempty_s;
  logic [15:0]       sel_a_s;
  logic [15:0]       sel_b_s;

  assign outstanding_s = inflight_q + cnt_q;
  assign fifo_nempty_s = (cnt_q != '0);

  // Rotate the request vector so the search always starts at rr_ptr, then undo the rotation.
  always_comb begin
    search_s = req_valid;
`ifdef MULT_SCHED_PRIO_EN
    search_s[0] = 1'b0;
`endif
    dbl_s = {search_s, search_s} >> rr_ptr_q;
    rot_s = dbl_s[NREQ-1:0];
    off_s = '0;
    hit_s = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot_s[k]) begin
        off_s = IDW'(k);
        hit_s = 1'b1;
      end else begin
        off_s = off_s;
      end
    end
    sum_s = {1'b0, rr_ptr_q} + {1'b0, off_s};
    if (sum_s >= NREQ_EXT) begin
      gnt_id_s = IDW'(sum_s - NREQ_EXT);
    end else begin
      gnt_id_s = sum_s[IDW-1:0];
    end
    rr_adv_s = 1'b1;
`ifdef MULT_SCHED_PRIO_EN
    if (req_valid[0]) begin
      gnt_id_s = '0;
      hit_s    = 1'b1;
      rr_adv_s = 1'b0;
    end else begin
      rr_adv_s = 1'b1;
    end
`endif
    credit_ok_s = (outstanding_s < CNT_MAX);
    if (hit_s && credit_ok_s) begin
      req_ready = OH_ONE << gnt_id_s;
    end else begin
      req_ready = '0;
    end
  end

  // Response side: FIFO head is presented to its owner only.
  always_comb begin
    if (fifo_nempty_s) begin
      rsp_valid = OH_ONE << fifo_id_q[rd_ptr_q];
      rsp_p     = fifo_p_q[rd_ptr_q];
    end else begin
      rsp_valid = '0;
      rsp_p     = 32'h0000_0000;
    end
  end

  // Next-state for issue stage, round-robin pointer, credit counters and FIFO pointers.
  always_comb begin
    xfer_s  = |(req_valid & req_ready);
    push_s  = tag_vld_q[LAT-1];
    pop_s   = |(rsp_valid & rsp_ready);
    sel_a_s = 16'h0000;
    sel_b_s = 16'h0000;
    for (int k = 0; k < NREQ; k++) begin
      if (req_ready[k]) begin
        sel_a_s = req_a[16*k +: 16];
        sel_b_s = req_b[16*k +: 16];
      end else begin
        sel_a_s = sel_a_s;
      end
    end

    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    mul_vld_d  = 1'b0;
    issue_id_d = issue_id_q;
    rr_ptr_d   = rr_ptr_q;
    if (xfer_s) begin
      mul_a_d    = sel_a_s;
      mul_b_d    = sel_b_s;
      mul_vld_d  = 1'b1;
      issue_id_d = gnt_id_s;
      if (rr_adv_s) begin
        rr_ptr_d = (gnt_id_s == ID_LAST) ? '0 : gnt_id_s + IDW'(1);
      end else begin
        rr_ptr_d = rr_ptr_q;
      end
    end else begin
      mul_vld_d = 1'b0;
    end

    case ({xfer_s, push_s})
      2'b10:   inflight_d = inflight_q + CNT_ONE;
      2'b01:   inflight_d = inflight_q - CNT_ONE;
      default: inflight_d = inflight_q;
    endcase

    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase

    wr_ptr_d = push_s ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop_s  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
  end

  // Control and issue registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rr_ptr_q   <= '0;
      inflight_q <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mul_a_q    <= 16'h0000;
      mul_b_q    <= 16'h0000;
      mul_vld_q  <= 1'b0;
      issue_id_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      mul_vld_q  <= mul_vld_d;
      issue_id_q <= issue_id_d;
    end
  end

  // Tag pipe tracks the multiplier stages so each product is captured with its owner ID.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tag_vld_q <= '0;
      for (int k = 0; k < LAT; k++) begin
        tag_id_q[k] <= '0;
      end
    end else begin
      tag_vld_q[0] <= mul_vld_q;
      tag_id_q[0]  <= issue_id_q;
      for (int k = 1; k < LAT; k++) begin
        tag_vld_q[k] <= tag_vld_q[k-1];
        tag_id_q[k]  <= tag_id_q[k-1];
      end
    end
  end

  // Result FIFO storage; credit accounting guarantees a free slot for every push.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int k = 0; k < FDEPTH; k++) begin
        fifo_p_q[k]  <= 32'h0000_0000;
        fifo_id_q[k] <= '0;
      end
    end else if (push_s) begin
      fifo_p_q[wr_ptr_q]  <= mul_p_i;
      fifo_id_q[wr_ptr_q] <= tag_id_q[LAT-1];
    end else begin
      fifo_p_q[wr_ptr_q]  <= fifo_p_q[wr_ptr_q];
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign mul_vld_o = mul_vld_q;
  assign busy      = (outstanding_s != '0) | mul_vld_q;

endmodule

// File: tb/tb_mult16_share_sched.sv
// Cycle-stepped bench for mult16_share_sched: directed scenarios plus random traffic,
// checked against a queue-based model of grants, credits and in-order responses.
module tb_mult16_share_sched;
  localparam int NREQ   = 4;
  localparam int LAT    = 3;
  localparam int FDEPTH = 4;

  logic                 sys_clk = 1'b0;
  logic                 sys_rst_n = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [16*NREQ-1:0]   req_a = '0;
  logic [16*NREQ-1:0]   req_b = '0;
  logic [15:0]          mul_a;
  logic [15:0]          mul_b;
  logic                 mul_vld_o;
  logic [31:0]          mul_p_i;
  logic [NREQ-1:0]      rsp_valid;
  logic [31:0]          rsp_p;
  logic [NREQ-1:0]      rsp_ready = '0;
  logic                 busy;

  logic [31:0] p_pipe [LAT];

  typedef struct {
    int          id;
    logic [31:0] p;
    int          vis;
  } op_t;

  op_t         q[$];
  int          rr = 0;
  int          cyc_n = 0;
  logic        exp_vld = 1'b0;
  logic [15:0] exp_a = 16'h0000;
  logic [15:0] exp_b = 16'h0000;
  int          checks = 0;
  int          failures = 0;

  mult16_share_sched #(.NREQ(NREQ), .LAT(LAT), .FDEPTH(FDEPTH)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_vld_o (mul_vld_o),
    .mul_p_i   (mul_p_i),
    .rsp_valid (rsp_valid),
    .rsp_p     (rsp_p),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [31:0] prod16(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] r;
    r = $signed(a) * $signed(b);
    return r;
  endfunction

  // Stand-in multiplier: fixed latency, garbage when the issue slot is empty.
  always @(posedge sys_clk) begin
    p_pipe[0] <= mul_vld_o ? prod16(mul_a, mul_b) : 32'hDEAD_BEEF;
    for (int k = 1; k < LAT; k++) p_pipe[k] <= p_pipe[k-1];
  end
  assign mul_p_i = p_pipe[LAT-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant();
    if (q.size() >= FDEPTH) return -1;
`ifdef MULT_SCHED_PRIO_EN
    if (req_valid[0]) return 0;
`endif
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (rr + k) % NREQ;
`ifdef MULT_SCHED_PRIO_EN
      if (idx == 0) continue;
`endif
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    q.delete();
    rr      = 0;
    exp_vld = 1'b0;
    exp_a   = 16'h0000;
    exp_b   = 16'h0000;
  endtask

  // Called at posedge+1 with inputs already applied; checks this cycle, then advances.
  task automatic cyc();
    int              g;
    logic [NREQ-1:0] e_rdy;
    logic [NREQ-1:0] e_rv;
    logic [31:0]     e_p;
    #2;
    g = model_grant();
    e_rdy = '0;
    if (g >= 0) e_rdy[g] = 1'b1;
    e_rv = '0;
    e_p  = 32'h0;
    if (q.size() > 0 && q[0].vis <= cyc_n) begin
      e_rv[q[0].id] = 1'b1;
      e_p = q[0].p;
    end
    chk("req_ready", 64'(req_ready), 64'(e_rdy));
    chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
    if (e_rv != '0) chk("rsp_p", 64'(rsp_p), 64'(e_p));
    chk("busy", 64'(busy), 64'(q.size() != 0));
    chk("mul_vld_o", 64'(mul_vld_o), 64'(exp_vld));
    chk("mul_a", 64'(mul_a), 64'(exp_a));
    chk("mul_b", 64'(mul_b), 64'(exp_b));
    if (e_rv != '0 && rsp_ready[q[0].id]) void'(q.pop_front());
    exp_vld = 1'b0;
    if (g >= 0) begin
      op_t o;
      o.id  = g;
      o.p   = prod16(req_a[16*g +: 16], req_b[16*g +: 16]);
      o.vis = cyc_n + 2 + LAT;
      q.push_back(o);
      exp_vld = 1'b1;
      exp_a   = req_a[16*g +: 16];
      exp_b   = req_b[16*g +: 16];
`ifdef MULT_SCHED_PRIO_EN
      if (g != 0) rr = (g + 1) % NREQ;
`else
      rr = (g + 1) % NREQ;
`endif
    end
    @(posedge sys_clk);
    #1;
    cyc_n++;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[16*i +: 16] = 16'($urandom);
      req_b[16*i +: 16] = 16'($urandom);
    end
  endtask

  task automatic drain(input int n);
    req_valid = '0;
    rsp_ready = '1;
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Issue one op from idle and check its product arrives exactly 2+LAT cycles later.
  task automatic single_op(input string tag, input int id, input logic [15:0] a,
                           input logic [15:0] b, input logic [31:0] p_exp);
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[id] = 1'b1;
    req_a[16*id +: 16] = a;
    req_b[16*id +: 16] = b;
    req_valid = oh;
    rsp_ready = '1;
    cyc();
    req_valid = '0;
    for (int i = 0; i < 1 + LAT; i++) cyc();
    #1;
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(oh));
    chk({tag, "_rsp_p"}, 64'(rsp_p), 64'(p_exp));
    cyc();
    drain(2);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    @(posedge sys_clk);
    @(posedge sys_clk);
    #1;
    chk("rst_mul_vld", 64'(mul_vld_o), 64'h0);
    chk("rst_mul_a", 64'(mul_a), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    sys_rst_n = 1'b1;
    model_reset();

    // T1 and T4: single ops with known products
    single_op("t1", 0, 16'h0003, 16'hFFFE, 32'hFFFF_FFFA);
    single_op("t4a", 2, 16'h8000, 16'h8000, 32'h4000_0000);
    single_op("t4b", 3, 16'h7FFF, 16'h8000, 32'hC000_8000);

    // T2: all requesters busy, responders always ready
    req_valid = '1;
    rsp_ready = '1;
    for (int i = 0; i < 24; i++) begin
      rand_ops();
      cyc();
    end
    drain(10);

    // T3: credit exhaustion then a single pop
    req_valid = '1;
    rsp_ready = '0;
    rand_ops();
    for (int i = 0; i < 10; i++) cyc();
    #1;
    chk("t3_no_credit", 64'(req_ready), 64'h0);
    rsp_ready = '0;
    rsp_ready[q[0].id] = 1'b1;
    cyc();
    rsp_ready = '0;
    for (int i = 0; i < 3; i++) cyc();
    drain(12);

    // T5: reset with three ops in flight
    rsp_ready = '1;
    for (int i = 0; i < 3; i++) begin
      req_valid = '0;
      req_valid[i] = 1'b1;
      rand_ops();
      cyc();
    end
    req_valid = '0;
    sys_rst_n = 1'b0;
    #1;
    chk("t5_mul_vld", 64'(mul_vld_o), 64'h0);
    chk("t5_mul_a", 64'(mul_a), 64'h0);
    chk("t5_mul_b", 64'(mul_b), 64'h0);
    chk("t5_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("t5_rsp_p", 64'(rsp_p), 64'h0);
    chk("t5_busy", 64'(busy), 64'h0);
    chk("t5_req_ready", 64'(req_ready), 64'h0);
    model_reset();
    @(posedge sys_clk);
    @(posedge sys_clk);
    #1;
    cyc_n += 2;
    sys_rst_n = 1'b1;
    req_valid = '1;
    #1;
    chk("t5_first_grant", 64'(req_ready), 64'h1);
    cyc();
    drain(12);

`ifdef MULT_SCHED_PRIO_EN
    // T6: requester 0 dominates, then the rest rotate
    req_valid = '1;
    rsp_ready = '1;
    for (int i = 0; i < 10; i++) begin
      rand_ops();
      cyc();
    end
    req_valid = 4'b1110;
    for (int i = 0; i < 10; i++) begin
      rand_ops();
      cyc();
    end
    drain(12);
`endif

    // Random traffic with random back-pressure
    for (int i = 0; i < 400; i++) begin
      req_valid = NREQ'($urandom);
      for (int k = 0; k < NREQ; k++) rsp_ready[k] = ($urandom_range(0, 9) < 7);
      rand_ops();
      if (i % 50 == 7) begin
        req_a[15:0] = 16'h8000;
        req_b[15:0] = 16'h7FFF;
      end
      cyc();
    end
    drain(16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
